// File: rtl/knn_bus_reader.sv
// Native-bus read initiator: fetches n_words consecutive words starting at base_addr
// and hands them downstream through a one-entry valid/ready output register.
module knn_bus_reader #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    n_words,
  output logic                busy,
  output logic                done,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  input  logic                out_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                m_valid_q, m_valid_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                beat;
  logic                accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      m_valid_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      m_valid_q   <= m_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    m_valid_d   = m_valid_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    accept = out_valid_q & out_ready;
    beat   = (state_q == S_REQ) & m_valid_q & m_ready;

    // A load in the same cycle as an accept wins, so out_valid stays high.
    if (accept) begin
      out_valid_d = 1'b0;
    end
    if (beat) begin
      out_valid_d = 1'b1;
      out_data_d  = m_rdata;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (n_words != '0) begin
            addr_d    = base_addr;
            cnt_d     = n_words;
            m_valid_d = 1'b1;
            state_d   = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (beat) begin
          m_valid_d = 1'b0;
          addr_d    = addr_q + ADDR_STEP;
          cnt_d     = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_DRAIN;
          end
        end else if (!m_valid_q && (!out_valid_q || out_ready)) begin
          // Only issue when the word already fetched cannot be overwritten.
          m_valid_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (accept) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign m_valid   = m_valid_q;
  assign m_addr    = addr_q;
  assign m_wdata   = '0;
  assign m_wstrb   = '0;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
